hex_snake_controller: RTL
=========================

HEX_SNAKE_CONTROLLER -- requirements
Module: hex_snake_controller

Interface
REQ-001 SHALL have parameter TICK_DIV, 1_000_000, CLK cycles per base tick (>=2).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, 50_000, stable-level cycles before a KEY change is accepted (>=1).
REQ-003 SHALL have port CLK input 1 — single clock; all logic on posedge CLK.
REQ-004 SHALL have port RST input 1 — reset, synchronous and active-high.
REQ-005 SHALL have port SW input 10 — SW[9:3] load pattern, SW[2:0] speed select.
REQ-006 SHALL have port KEY input 4 — active-low buttons: [0] run/pause, [1] single step, [2] direction toggle, [3] load.
REQ-007 SHALL have port LED output 10 — LED[0] RUN, LED[1] PAUSE, LED[2] direction (1 = right), LED[9:3] current pattern.
REQ-008 SHALL have ports HEX0..HEX5 output 7 each — active-high segment patterns.

Function
REQ-009 SHALL synchronise each KEY bit with 2 flops, then debounce: a level is accepted only after DEBOUNCE_CYCLES consecutive equal samples.
REQ-010 SHALL emit a one-cycle press pulse per accepted high->low transition; the pulse occurs DEBOUNCE_CYCLES+2 cycles after the first edge sampling KEY low, provided KEY stays low throughout.
REQ-011 SHALL hold one press per physical press: no repeat while held; glitches shorter than DEBOUNCE_CYCLES produce no pulse.
REQ-012 SHALL run a base prescaler 0..TICK_DIV-1, asserting base_tick on TICK_DIV-1; it free-runs in every state.
REQ-013 SHALL count base ticks in RUN only; a step fires when base_tick and count >= SW[2:0], then count clears. Period = TICK_DIV*(SW[2:0]+1) cycles; a lowered SW[2:0] mid-count fires on the next base_tick.
REQ-014 SHALL implement FSM states IDLE, RUN, PAUSE.
REQ-015 On press[0]: IDLE->RUN, RUN->PAUSE, PAUSE->RUN. Entering RUN clears the step count and prescaler.
REQ-016 On press[1] in IDLE or PAUSE, SHALL perform exactly one step on the following edge; ignored in RUN.
REQ-017 On press[2], SHALL toggle direction in any state; takes effect from the next step.
REQ-018 On press[3], SHALL load pattern <= SW[9:3] in any state without changing state; SW[9:3]==0 loads 7'h01.
REQ-019 Step left SHALL be pattern <= {p[5:0],p[6]}; step right SHALL be pattern <= {p[0],p[6:1]}.
REQ-020 Same-cycle priority: load > step (timer or press[1]); run/pause and direction changes apply alongside; a load suppresses any coincident step.
REQ-021 HEX0 SHALL equal pattern; HEXn SHALL equal HEX(n-1) rotated left by one (HEX1 = {HEX0[5:0],HEX0[6]}, etc.), combinationally.
REQ-022 Pattern SHALL never become zero; popcount is preserved by steps.

Reset
REQ-023 With RST high at a CLK edge: state IDLE, direction left, pattern 7'h01, prescaler/count 0, debouncers at released level, no pending pulses.
REQ-024 Reset outputs: HEX0..HEX5 = 01,02,04,08,10,20 (hex); LED = 10'h008.
REQ-025 RST asserted mid-operation SHALL override all presses and steps in that cycle; no press pulse is emitted for a key already held at reset release until it is released and pressed again.

Structure
REQ-026 Shared package hex_snake_pkg SHALL hold the FSM state type, PATTERN_W=7, NUM_HEX=6, reset pattern 7'h01, and rotate-left/right functions.
REQ-027 SHALL instantiate sub-module key_conditioner (sync + debounce + press pulse) once per KEY bit, parameterised by DEBOUNCE_CYCLES.

Verification (TICK_DIV=4, DEBOUNCE_CYCLES=3)
REQ-028 Reset, SW=0, no keys for 100 cycles -> HEX0=01, HEX5=20, LED=008, no motion.
REQ-029 Press KEY[0] (held 10 cycles), SW[2:0]=1 -> RUN, LED[0]=1; HEX0 steps 01->02->04 every 8 cycles.
REQ-030 In PAUSE, press KEY[2] then KEY[1] -> LED[2]=1; one step right, HEX0 04->02; no further motion.
REQ-031 SW[9:3]=0 and press KEY[3] in RUN, coincident with a timer step -> HEX0=01 (load wins); SW[9:3]=7'h41 load -> HEX0=41, HEX1=03.
REQ-032 KEY[0] glitch low 2 cycles -> no state change; held low 40 cycles -> exactly one toggle.
REQ-033 RST pulsed mid-RUN with KEY[1] held -> all outputs at reset values, IDLE, no step until KEY[1] released and re-pressed.

Source files
------------

// File: rtl/hex_snake_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hex_snake_pkg
//  Description : Shared types, constants and rotate helpers for the
//                hex_snake_controller block.
//  Contents    : state_t (IDLE/RUN/PAUSE), PATTERN_W, NUM_HEX,
//                RESET_PATTERN, rotl(), rotr()
//  Revision    : 1.0 - initial release
// ============================================================================
package hex_snake_pkg;

  localparam int PATTERN_W = 7;
  localparam int NUM_HEX   = 6;

  localparam logic [PATTERN_W-1:0] RESET_PATTERN = 7'h01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  // Rotate left by one: MSB wraps into bit 0.
  function automatic logic [PATTERN_W-1:0] rotl(input logic [PATTERN_W-1:0] p);
    return {p[PATTERN_W-2:0], p[PATTERN_W-1]};
  endfunction

  // Rotate right by one: bit 0 wraps into the MSB.
  function automatic logic [PATTERN_W-1:0] rotr(input logic [PATTERN_W-1:0] p);
    return {p[0], p[PATTERN_W-1:1]};
  endfunction

endpackage : hex_snake_pkg
`default_nettype wire

// File: rtl/hex_snake_controller_key_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : key_conditioner
//  Description : Two-flop synchroniser, level debouncer and press-pulse
//                generator for one active-low push button.
//  Ports       : clk      - clock
//                rst      - synchronous active-high reset
//                i_key_n  - raw asynchronous button level (0 = pressed)
//                o_press  - one-cycle pulse per accepted press
//  Revision    : 1.0 - initial release
// ============================================================================
module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_key_n,
  output logic o_press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic          r_stable_d;
  logic          r_armed;
  logic [CW-1:0] r_cnt;
  logic          r_press;

  // The synchroniser resets to the pressed level and the conditioner starts
  // disarmed: it only arms after DEBOUNCE_CYCLES consecutive released
  // samples, so a key held across reset release cannot produce a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_stable   <= 1'b1;
      r_stable_d <= 1'b1;
      r_armed    <= 1'b0;
      r_cnt      <= '0;
      r_press    <= 1'b0;
    end else begin
      r_sync1    <= i_key_n;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      r_press    <= r_armed & r_stable_d & ~r_stable;

      if (!r_armed) begin
        if (!r_sync2) begin
          r_cnt <= '0;
        end else if (r_cnt == C_LAST) begin
          r_armed <= 1'b1;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        if (r_sync2 == r_stable) begin
          r_cnt <= '0;
        end else if (r_cnt == C_LAST) begin
          r_stable <= r_sync2;
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign o_press = r_press;

endmodule : key_conditioner
`default_nettype wire

// File: rtl/hex_snake_controller.sv
`default_nettype none
// ============================================================================
//  Module      : hex_snake_controller
//  Description : Rotating 7-bit "snake" pattern shown on six seven-segment
//                displays, with run/pause, single step, direction and load
//                buttons and a switch-selected step rate.
//  Ports       : CLK        - clock
//                RST        - synchronous active-high reset
//                SW[9:3]    - load pattern, SW[2:0] speed select
//                KEY[3:0]   - active-low buttons: run/pause, step, dir, load
//                LED[9:0]   - {pattern, direction, PAUSE, RUN}
//                HEX0..HEX5 - active-high segment patterns
//  Revision    : 1.0 - initial release
// ============================================================================
module hex_snake_controller
  import hex_snake_pkg::*;
#(
  parameter int TICK_DIV        = 1_000_000,
  parameter int DEBOUNCE_CYCLES = 50_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [9:0] SW,
  input  logic [3:0] KEY,
  output logic [9:0] LED,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] C_PRESC_LAST = PW'(TICK_DIV - 1);

  state_t                r_state;
  state_t                w_state_next;
  logic [PW-1:0]         r_presc;
  logic [2:0]            r_cnt;
  logic                  r_dir;      // 1 = right
  logic [PATTERN_W-1:0]  r_pattern;

  logic [3:0]            w_press;
  logic                  w_base_tick;
  logic                  w_timer_step;
  logic                  w_man_step;
  logic                  w_enter_run;
  logic [PATTERN_W-1:0]  w_load_val;
  logic [PATTERN_W-1:0]  w_hex [NUM_HEX];

  for (genvar gi = 0; gi < 4; gi++) begin : g_key
    key_conditioner #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key (
      .clk     (CLK),
      .rst     (RST),
      .i_key_n (KEY[gi]),
      .o_press (w_press[gi])
    );
  end

  // FSM next state
  always_comb begin
    w_state_next = r_state;
    if (w_press[0]) begin
      case (r_state)
        ST_IDLE:  w_state_next = ST_RUN;
        ST_RUN:   w_state_next = ST_PAUSE;
        ST_PAUSE: w_state_next = ST_RUN;
        default:  w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  assign w_base_tick  = (r_presc == C_PRESC_LAST);
  assign w_timer_step = (r_state == ST_RUN) && w_base_tick && (r_cnt >= SW[2:0]);
  assign w_man_step   = w_press[1] && (r_state != ST_RUN);
  assign w_enter_run  = (r_state != ST_RUN) && (w_state_next == ST_RUN);
  assign w_load_val   = (SW[9:3] == '0) ? RESET_PATTERN : SW[9:3];

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_presc   <= '0;
      r_cnt     <= '0;
      r_dir     <= 1'b0;
      r_pattern <= RESET_PATTERN;
    end else begin
      // Prescaler free-runs in every state; it restarts on entry to RUN so
      // the first step is a full period after the button press.
      if (w_enter_run || w_base_tick) begin
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + PW'(1);
      end

      // The count never exceeds 7, so a 3-bit counter cannot wrap before
      // the >= comparison fires.
      if (w_enter_run) begin
        r_cnt <= '0;
      end else if ((r_state == ST_RUN) && w_base_tick) begin
        r_cnt <= w_timer_step ? 3'd0 : r_cnt + 3'd1;
      end

      if (w_press[2]) begin
        r_dir <= ~r_dir;
      end

      // A load overrides any step in the same cycle.
      if (w_press[3]) begin
        r_pattern <= w_load_val;
      end else if (w_timer_step || w_man_step) begin
        r_pattern <= r_dir ? rotr(r_pattern) : rotl(r_pattern);
      end
    end
  end

  assign w_hex[0] = r_pattern;
  for (genvar gh = 1; gh < NUM_HEX; gh++) begin : g_hex
    assign w_hex[gh] = rotl(w_hex[gh-1]);
  end

  assign HEX0 = w_hex[0];
  assign HEX1 = w_hex[1];
  assign HEX2 = w_hex[2];
  assign HEX3 = w_hex[3];
  assign HEX4 = w_hex[4];
  assign HEX5 = w_hex[5];

  assign LED = {r_pattern, r_dir, (r_state == ST_PAUSE), (r_state == ST_RUN)};

endmodule : hex_snake_controller
`default_nettype wire
